// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage.
package if_pkg;

    localparam int unsigned ILEN      = 32;
    localparam int unsigned PC_STEP   = 4;
    // addi x0, x0, 0: idle value for the instruction bus
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instruction} entries for decode.
// Flush wins over push and pop in the same cycle.
module fetch_buffer #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);

    // Entry storage; cleared on reset so the head reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the fetch PC, issues one instruction-memory request at a
// time and queues returned {pc, instruction} pairs for decode. A redirect
// reloads the PC, flushes the queue and discards any in-flight response.
module instruction_fetch_stage
    import if_pkg::*;
#(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instruction,
    output logic [XLEN-1:0] if_pc
);

    localparam int unsigned ENTRY_W = XLEN + ILEN;
    localparam int unsigned CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BUF_CNT = CNT_W'(BUF_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             push;
    logic             pop;
    logic [ENTRY_W-1:0] head_data;
    logic [CNT_W-1:0] buf_count;
    logic             buf_full;
    logic             buf_empty;
    logic [XLEN-1:0]  redirect_pc;

    assign redirect_pc = {redirect_target[XLEN-1:2], 2'b00};

    // Requests are held off in reset, when the queue has no room, and during a redirect
    assign imem_req_valid = !rst && (state_q == S_REQ) && (buf_count < BUF_CNT)
                            && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;

    assign if_valid       = !buf_empty;
    assign if_pc          = head_data[ENTRY_W-1:ILEN];
    assign if_instruction = head_data[ILEN-1:0];
    assign pop            = if_valid && if_ready;

    // Next-state, PC update and push decision
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        unique case (state_q)
            S_REQ: begin
                // Responses here are protocol violations and are ignored
                if (!redirect_valid && imem_req_valid && imem_req_ready) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
                    req_pc_d   = fetch_pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_resp_valid ? S_REQ : S_DROP;
                end else if (imem_resp_valid) begin
                    push    = !buf_full;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                // The stale response is consumed even if another redirect
                // lands with it; staying here would wait for a response that
                // never comes.
                if (imem_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        if (redirect_valid) fetch_pc_d = redirect_pc;
    end

    // State and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_buffer #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({req_pc_q, imem_resp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_data),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

endmodule
